// File: rtl/seg_pkg.sv
// Shared types and segment tables for the seven-segment display blocks.
// Segment codes are {g,f,e,d,c,b,a}, active-low, for common-anode parts.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scanState_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // One full display image: what a single load captures.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } dispData_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and
// frame-synchronous double buffering. Option: SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 104166,
    parameter int BLANK_CYC = 1000
)
(
    input  logic        inClk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic        pending,
    output logic        frame_done,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int               CNT_W      = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    scanState_t       state;
    scanState_t       stateNext;
    logic             isWrap;
    logic             isBoundary;

    dispData_t        activeReg;
    dispData_t        shadowReg;
    dispData_t        loadData;

    logic [3:0]       nibble;
    logic [6:0]       segDec;
    logic [3:0]       lzSuppress;
    logic             digDark;
    logic [3:0]       anNext;
    logic [6:0]       segNext;
    logic             dpNext;

    assign isWrap     = (cnt == CNT_LAST);
    assign isBoundary = isWrap && (dig == 2'(NUM_DIGITS - 1));
    assign loadData   = {data_in, dp_in, blank_in};

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            dig   <= '0;
            state <= ST_BLANK;
        end else begin
            cnt   <= isWrap ? '0 : cnt + 1'b1;
            state <= stateNext;
            if (isWrap)
                dig <= dig + 1'b1;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        stateNext = state;
        case (state)
            ST_BLANK: if (cnt == BLANK_LAST) stateNext = ST_DRIVE;
            ST_DRIVE: if (isWrap)            stateNext = ST_BLANK;
            default:                         stateNext = ST_BLANK;
        endcase
    end

    // NOTE: the display buffers are plain flops, not RAM, so they take the async clear.
    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            activeReg <= '0;
            shadowReg <= '0;
            pending   <= 1'b0;
        end else if (isBoundary) begin
            // A load landing on the boundary bypasses the shadow entirely.
            if (load)
                activeReg <= loadData;
            else if (pending)
                activeReg <= shadowReg;
            pending <= 1'b0;
        end else if (load) begin
            shadowReg <= loadData;
            pending   <= 1'b1;
        end
    end

    assign nibble = activeReg.data[{dig, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg_n  (segDec)
    );

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic higherDark;

    // Walk from the top digit down; a zero stays dark only while everything above is dark too.
    always_comb begin
        higherDark = 1'b1;
        lzSuppress = '0;
        for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
            lzSuppress[n] = higherDark && (activeReg.data[4*n +: 4] == 4'h0) && !activeReg.dp[n];
            higherDark    = higherDark && ((activeReg.data[4*n +: 4] == 4'h0) || activeReg.blank[n]);
        end
    end
`else
    assign lzSuppress = '0;
`endif

    assign digDark = activeReg.blank[dig] | lzSuppress[dig];

    always_comb begin
        anNext  = 4'hF;
        segNext = SEG_OFF;
        dpNext  = 1'b1;
        if (state == ST_DRIVE && !digDark) begin
            anNext[dig] = 1'b0;
            segNext     = segDec;
            dpNext      = ~activeReg.dp[dig];
        end
    end

    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            an_n       <= 4'hF;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an_n       <= anNext;
            seg_n      <= segNext;
            dp_n       <= dpNext;
            frame_done <= isBoundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle scoreboard against a slot-arithmetic
// model, a decode vector table, and hand sequences for buffering and reset corners.
module tb_seg_scan_ctrl;

    localparam int TICK  = 8;
    localparam int BLANK = 2;

    logic        inClk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [6:0] expSeg;
        logic       expDpN;
    } vec_t;

    vec_t  vecs [16];

    // Model: k counts clock edges since reset release; slot position and digit follow by arithmetic.
    int    k;
    disp_t mAct;
    disp_t mShadow;
    bit    mPending;
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    logic       eFrame;
    bit         eDarkDrive;

    seg_scan_ctrl #(.TICK_DIV(TICK), .BLANK_CYC(BLANK)) dut (
        .inClk      (inClk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n)
    );

    always #5 inClk = ~inClk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic logic [3:0] nibOf(disp_t a, int d);
        return a.data[4*d +: 4];
    endfunction

    function automatic bit isDark(disp_t a, int d);
        if (a.blank[d]) return 1'b1;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        if (d > 0 && nibOf(a, d) == 4'h0 && !a.dp[d]) begin
            bit allHigh = 1'b1;
            for (int m = d + 1; m < 4; m++)
                if (nibOf(a, m) != 4'h0 && !a.blank[m]) allHigh = 1'b0;
            if (allHigh) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then compare at the negedge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dv, input logic [3:0] bv);
        int    pos;
        int    dg;
        disp_t inp;
        load = ld; data_in = d; dp_in = dv; blank_in = bv;
        pos = k % TICK;
        dg  = (k / TICK) % 4;
        eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1; eDarkDrive = 1'b0;
        if (pos >= BLANK) begin
            if (isDark(mAct, dg)) begin
                eDarkDrive = 1'b1;
            end else begin
                eAn[dg] = 1'b0;
                eSeg    = vecs[nibOf(mAct, dg)].expSeg;
                eDp     = ~mAct.dp[dg];
            end
        end
        eFrame = (pos == TICK - 1) && (dg == 3);
        inp = '{d, dv, bv};
        if (eFrame) begin
            if (ld) mAct = inp;
            else if (mPending) mAct = mShadow;
            mPending = 1'b0;
        end else if (ld) begin
            mShadow  = inp;
            mPending = 1'b1;
        end
        k++;
        @(posedge inClk);
        @(negedge inClk);
        load = 1'b0;
        check("an_n", 16'(an_n), 16'(eAn));
        if (!eDarkDrive) begin
            check("seg_n", 16'(seg_n), 16'(eSeg));
            check("dp_n", 16'(dp_n), 16'(eDp));
        end
        check("frame_done", 16'(frame_done), 16'(eFrame));
        check("pending", 16'(pending), 16'(mPending));
    endtask

    task automatic idle();
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // Step until the next edge will be taken from slot position p of digit dg.
    task automatic advanceTo(input int p, input int dg);
        for (int i = 0; i < 200; i++) begin
            if (k % TICK == p && (k / TICK) % 4 == dg) return;
            idle();
        end
        total++;
        bad++;
        $display("FAIL advanceTo: slot pos %0d digit %0d not reached within 200 cycles", p, dg);
    endtask

    // Assert reset between edges, check the asynchronous clear, release on a later negedge.
    task automatic resetDut();
        reset = 1'b1;
        #1;
        check("rst an_n", 16'(an_n), 16'hF);
        check("rst seg_n", 16'(seg_n), 16'h7F);
        check("rst dp_n", 16'(dp_n), 16'h1);
        check("rst pending", 16'(pending), 16'h0);
        check("rst frame_done", 16'(frame_done), 16'h0);
        @(negedge inClk);
        reset    = 1'b0;
        k        = 0;
        mAct     = '{16'h0, 4'h0, 4'h0};
        mShadow  = '{16'h0, 4'h0, 4'h0};
        mPending = 1'b0;
    endtask

    initial begin
        int  anLow2;
        int  dpSeen;

        vecs[0]  = '{4'h0, 1'b0, 7'b1000000, 1'b1};
        vecs[1]  = '{4'h1, 1'b1, 7'b1111001, 1'b0};
        vecs[2]  = '{4'h2, 1'b0, 7'b0100100, 1'b1};
        vecs[3]  = '{4'h3, 1'b1, 7'b0110000, 1'b0};
        vecs[4]  = '{4'h4, 1'b0, 7'b0011001, 1'b1};
        vecs[5]  = '{4'h5, 1'b1, 7'b0010010, 1'b0};
        vecs[6]  = '{4'h6, 1'b0, 7'b0000010, 1'b1};
        vecs[7]  = '{4'h7, 1'b1, 7'b1111000, 1'b0};
        vecs[8]  = '{4'h8, 1'b0, 7'b0000000, 1'b1};
        vecs[9]  = '{4'h9, 1'b1, 7'b0010000, 1'b0};
        vecs[10] = '{4'hA, 1'b0, 7'b0001000, 1'b1};
        vecs[11] = '{4'hB, 1'b1, 7'b0000011, 1'b0};
        vecs[12] = '{4'hC, 1'b0, 7'b1000110, 1'b1};
        vecs[13] = '{4'hD, 1'b1, 7'b0100001, 1'b0};
        vecs[14] = '{4'hE, 1'b0, 7'b0000110, 1'b1};
        vecs[15] = '{4'hF, 1'b1, 7'b0001110, 1'b0};

        reset = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
        k = 0;
        @(negedge inClk);
        resetDut();

        // Scan order: load 1234 at cycle 3, visible from the following frame.
        idle(); idle(); idle();
        step(1'b1, 16'h1234, 4'h0, 4'h0);
        advanceTo(7, 3); idle();
        advanceTo(3, 0); step(1'b0, 16'h0, 4'h0, 4'h0);
        check("scan d0 an", 16'(an_n), 16'hE);
        check("scan d0 seg", 16'(seg_n), 16'(7'b0011001));
        advanceTo(1, 1); idle();
        check("slot blank an", 16'(an_n), 16'hF);
        idle();
        check("scan d1 an", 16'(an_n), 16'hD);
        check("scan d1 seg", 16'(seg_n), 16'(7'b0110000));
        advanceTo(4, 3); idle();
        check("scan d3 an", 16'(an_n), 16'h7);
        check("scan d3 seg", 16'(seg_n), 16'(7'b1111001));

        // Tear-free update: AAAA loaded during digit 1 waits for the boundary.
        advanceTo(2, 1); step(1'b1, 16'hAAAA, 4'h0, 4'h0);
        check("tear pending", 16'(pending), 16'h1);
        advanceTo(4, 2); idle();
        check("tear old d2", 16'(seg_n), 16'(7'b0100100));
        advanceTo(7, 3); idle();
        check("tear frame_done", 16'(frame_done), 16'h1);
        check("tear commit", 16'(pending), 16'h0);
        advanceTo(4, 0); idle();
        check("tear new d0", 16'(seg_n), 16'(7'b0001000));

        // Load coincident with the boundary goes straight to the active image.
        advanceTo(7, 3); step(1'b1, 16'h8888, 4'h0, 4'h0);
        check("coinc pending", 16'(pending), 16'h0);
        check("coinc frame_done", 16'(frame_done), 16'h1);
        advanceTo(2, 0); idle();
        check("coinc an", 16'(an_n), 16'hE);
        check("coinc seg", 16'(seg_n), 16'(7'b0000000));

        // Forced blank on digit 2 and decimal point on digit 0 over one full frame.
        advanceTo(7, 3); step(1'b1, 16'h1234, 4'b0001, 4'b0100);
        anLow2 = 0; dpSeen = 0;
        for (int i = 0; i < 4 * TICK; i++) begin
            idle();
            if (an_n[2] == 1'b0) anLow2++;
            if (an_n == 4'hE && dp_n == 1'b0) dpSeen++;
        end
        check("blank d2 anode cycles", 16'(anLow2), 16'd0);
        check("dp d0 cycles", 16'(dpSeen), 16'(TICK - BLANK));

        // Reset mid-DRIVE with a load still pending.
        advanceTo(7, 3); step(1'b1, 16'h5555, 4'h0, 4'h0);
        advanceTo(1, 1); step(1'b1, 16'h9999, 4'h0, 4'h0);
        advanceTo(5, 2);
        check("pre-rst d2 lit", 16'(an_n), 16'hB);
        resetDut();
        advanceTo(3, 0); idle();
        check("post-rst d0 an", 16'(an_n), 16'hE);
        check("post-rst d0 seg", 16'(seg_n), 16'(7'b1000000));

        // Decode table through digit 0.
        for (int i = 0; i < 16; i++) begin
            advanceTo(7, 3);
            step(1'b1, {4{vecs[i].nib}}, {4{vecs[i].dp}}, 4'h0);
            advanceTo(3, 0); idle();
            check("vec an", 16'(an_n), 16'hE);
            check("vec seg", 16'(seg_n), 16'(vecs[i].expSeg));
            check("vec dp", 16'(dp_n), 16'(vecs[i].expDpN));
        end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        advanceTo(7, 3); step(1'b1, 16'h0070, 4'h0, 4'h0);
        advanceTo(3, 3); idle();
        check("lz d3 dark", 16'(an_n), 16'hF);
        advanceTo(3, 1); idle();
        check("lz d1 an", 16'(an_n), 16'hD);
        check("lz d1 seg", 16'(seg_n), 16'(7'b1111000));
        advanceTo(3, 0); idle();
        check("lz d0 seg", 16'(seg_n), 16'(7'b1000000));
        advanceTo(7, 3); step(1'b1, 16'h0000, 4'h0, 4'h0);
        advanceTo(3, 1); idle();
        check("lz zero d1 dark", 16'(an_n), 16'hF);
        advanceTo(3, 0); idle();
        check("lz zero d0 lit", 16'(an_n), 16'hE);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
